// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore control state machine for the 16-bit multi-cycle processor. Each
// instruction moves through fetch, decode, execute, memory and writeback
// states. Every select output is decoded from the state register alone.
// The write strobes are additionally gated by Enable and Reset.
//
// Ports
//   CLK                clock, rising edge
//   Reset              asynchronous, active-high reset
//   Enable             1 = advance; 0 = hold state and gate write strobes
//   input_opcode[6:0]  IR control field, sampled only in DECODE
//   output_PCWrite     unconditional PC update
//   output_PCSource    00 ALU result, 01 ALUOut, 10 IR immediate
//   output_isBranch    conditional PC update (qualified downstream)
//   output_branchType  branch condition select (latched opcode[1:0])
//   output_IorD        0 = address from PC, 1 = address from ALUOut
//   output_IRWrite     IR load strobe
//   output_MemWrite    memory write strobe
//   output_RegWrite    register-file write strobe
//   output_MemToReg    writeback source: 1 = MDR, 0 = ALUOut
//   output_ALUSrcA     0 = PC, 1 = regA
//   output_ALUSrcB     00 regB, 01 constant 2, 10 immediate
//   output_ALUOp       00 add, 01 sub, 10 funct-driven, 11 opcode-driven
//   output_halted      FSM is in HALT
//   output_illegal     sticky: undefined opcode or unreachable state seen
//   output_state       current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [6:0]         input_opcode,
    output logic               output_PCWrite,
    output logic [1:0]         output_PCSource,
    output logic               output_isBranch,
    output logic [1:0]         output_branchType,
    output logic               output_IorD,
    output logic               output_IRWrite,
    output logic               output_MemWrite,
    output logic               output_RegWrite,
    output logic               output_MemToReg,
    output logic               output_ALUSrcA,
    output logic [1:0]         output_ALUSrcB,
    output logic [1:0]         output_ALUOp,
    output logic               output_halted,
    output logic               output_illegal,
    output logic [STATE_W-1:0] output_state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        HALT      = 4'd11
    } state_t;

    state_t     state_q;
    state_t     state_next;
    logic [6:0] opcode_q;
    logic       illegal_q;
    logic       bad_state;
    logic       opcode_legal;
    logic       in_decode;

    // Raw strobes before Enable/Reset gating.
    logic       pc_write_raw;
    logic       is_branch_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       strobe_gate;

    // Encodings 12-15 are not in the state list. They can only appear after an
    // upset. Recovery to HALT does not wait for Enable, so a stalled pipeline
    // cannot sit in an undefined state.
    assign bad_state = (state_q > HALT);
    assign in_decode = (state_q == DECODE);

    always_comb begin
        opcode_legal = 1'b0;
        case (input_opcode)
            7'h01, 7'h02, 7'h03, 7'h04,
            7'h08, 7'h09, 7'h0A, 7'h0B,
            7'h0C, 7'h7F: opcode_legal = 1'b1;
            default:      opcode_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
        end else if (Enable || bad_state) begin
            state_q <= state_next;
        end
    end

    // Opcode copy used by MEM_ADDR routing and by branchType
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            opcode_q <= 7'h00;
        end else if (Enable && in_decode) begin
            opcode_q <= input_opcode;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else if (bad_state || (Enable && in_decode && !opcode_legal)) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next        = state_q;
        pc_write_raw      = 1'b0;
        output_PCSource   = 2'b00;
        is_branch_raw     = 1'b0;
        output_branchType = 2'b00;
        output_IorD       = 1'b0;
        ir_write_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        reg_write_raw     = 1'b0;
        output_MemToReg   = 1'b0;
        output_ALUSrcA    = 1'b0;
        output_ALUSrcB    = 2'b00;
        output_ALUOp      = 2'b00;
        output_halted     = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write_raw   = 1'b1;
                output_ALUSrcB = 2'b01;
                pc_write_raw   = 1'b1;
                state_next     = DECODE;
            end
            DECODE: begin
                // Branch target (PC + immediate) is computed here into ALUOut.
                output_ALUSrcB = 2'b10;
                case (input_opcode)
                    7'h01:                      state_next = EXEC_R;
                    7'h02:                      state_next = EXEC_I;
                    7'h03, 7'h04:               state_next = MEM_ADDR;
                    7'h08, 7'h09, 7'h0A, 7'h0B: state_next = BRANCH;
                    7'h0C:                      state_next = JUMP;
                    default:                    state_next = HALT;
                endcase
            end
            EXEC_R: begin
                output_ALUSrcA = 1'b1;
                output_ALUSrcB = 2'b00;
                output_ALUOp   = 2'b10;
                state_next     = ALU_WB;
            end
            EXEC_I: begin
                output_ALUSrcA = 1'b1;
                output_ALUSrcB = 2'b10;
                output_ALUOp   = 2'b11;
                state_next     = ALU_WB;
            end
            ALU_WB: begin
                reg_write_raw = 1'b1;
                state_next    = FETCH;
            end
            MEM_ADDR: begin
                output_ALUSrcA = 1'b1;
                output_ALUSrcB = 2'b10;
                // Only load and store reach this state, so store is the only
                // case that needs a separate test.
                state_next     = (opcode_q == 7'h04) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                output_IorD = 1'b1;
                state_next  = MEM_WB;
            end
            MEM_WB: begin
                reg_write_raw   = 1'b1;
                output_MemToReg = 1'b1;
                state_next      = FETCH;
            end
            MEM_WRITE: begin
                output_IorD   = 1'b1;
                mem_write_raw = 1'b1;
                state_next    = FETCH;
            end
            BRANCH: begin
                output_ALUSrcA    = 1'b1;
                output_ALUSrcB    = 2'b00;
                output_ALUOp      = 2'b01;
                is_branch_raw     = 1'b1;
                output_branchType = opcode_q[1:0];
                output_PCSource   = 2'b01;
                state_next        = FETCH;
            end
            JUMP: begin
                pc_write_raw    = 1'b1;
                output_PCSource = 2'b10;
                state_next      = FETCH;
            end
            HALT: begin
                output_halted = 1'b1;
                state_next    = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // While Enable is low, or Reset is high, no write strobe may reach the
    // datapath. isBranch is a PC write in disguise, so Enable gates it too.
    assign strobe_gate     = Enable & ~Reset;
    assign output_PCWrite  = pc_write_raw  & strobe_gate;
    assign output_IRWrite  = ir_write_raw  & strobe_gate;
    assign output_MemWrite = mem_write_raw & strobe_gate;
    assign output_RegWrite = reg_write_raw & strobe_gate;
    assign output_isBranch = is_branch_raw & Enable;

    assign output_illegal  = illegal_q;
    assign output_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm. The driver applies inputs 1ns
// after each rising edge. For each cycle it pushes the expected output bundle,
// taken from a hand-written per-state table. A monitor pops one entry on every
// falling edge and compares it with the bundle the DUT presents.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_MEM_ADDR  = 4'd4;
    localparam logic [3:0] S_MEM_READ  = 4'd5;
    localparam logic [3:0] S_MEM_WB    = 4'd6;
    localparam logic [3:0] S_MEM_WRITE = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_HALT      = 4'd11;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b1;
    logic [6:0] input_opcode = 7'h00;

    always #5 CLK = ~CLK;

    logic       output_PCWrite;
    logic [1:0] output_PCSource;
    logic       output_isBranch;
    logic [1:0] output_branchType;
    logic       output_IorD;
    logic       output_IRWrite;
    logic       output_MemWrite;
    logic       output_RegWrite;
    logic       output_MemToReg;
    logic       output_ALUSrcA;
    logic [1:0] output_ALUSrcB;
    logic [1:0] output_ALUOp;
    logic       output_halted;
    logic       output_illegal;
    logic [3:0] output_state;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .CLK               (CLK),
        .Reset             (Reset),
        .Enable            (Enable),
        .input_opcode      (input_opcode),
        .output_PCWrite    (output_PCWrite),
        .output_PCSource   (output_PCSource),
        .output_isBranch   (output_isBranch),
        .output_branchType (output_branchType),
        .output_IorD       (output_IorD),
        .output_IRWrite    (output_IRWrite),
        .output_MemWrite   (output_MemWrite),
        .output_RegWrite   (output_RegWrite),
        .output_MemToReg   (output_MemToReg),
        .output_ALUSrcA    (output_ALUSrcA),
        .output_ALUSrcB    (output_ALUSrcB),
        .output_ALUOp      (output_ALUOp),
        .output_halted     (output_halted),
        .output_illegal    (output_illegal),
        .output_state      (output_state)
    );

    // Bundle layout:
    // {state, PCWrite, PCSource, isBranch, branchType, IorD, IRWrite, MemWrite,
    //  RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp, halted, illegal}
    logic [21:0] dut_vec;
    assign dut_vec = {output_state, output_PCWrite, output_PCSource,
                      output_isBranch, output_branchType, output_IorD,
                      output_IRWrite, output_MemWrite, output_RegWrite,
                      output_MemToReg, output_ALUSrcA, output_ALUSrcB,
                      output_ALUOp, output_halted, output_illegal};

    // ---------------- scoreboard ----------------
    logic [21:0] exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [1:0]  exp_bt      = 2'b00;
    logic        exp_illegal = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Hand-written per-state table of expected outputs.
    function automatic logic [21:0] exp_vec(input logic [3:0] st,
                                            input logic en, input logic rst);
        logic       pcw, isb, iord, irw, memw, regw, m2r, srca, hlt;
        logic [1:0] pcs, bt, srcb, aluop;
        pcw = 0; isb = 0; iord = 0; irw = 0; memw = 0; regw = 0; m2r = 0;
        srca = 0; hlt = 0; pcs = 2'b00; bt = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (st)
            S_FETCH:     begin irw = 1; srcb = 2'b01; pcw = 1; end
            S_DECODE:    begin srcb = 2'b10; end
            S_EXEC_R:    begin srca = 1; srcb = 2'b00; aluop = 2'b10; end
            S_EXEC_I:    begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
            S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
            S_MEM_READ:  begin iord = 1; end
            S_MEM_WB:    begin regw = 1; m2r = 1; end
            S_MEM_WRITE: begin iord = 1; memw = 1; end
            S_ALU_WB:    begin regw = 1; end
            S_BRANCH:    begin srca = 1; aluop = 2'b01; isb = 1; bt = exp_bt;
                               pcs = 2'b01; end
            S_JUMP:      begin pcw = 1; pcs = 2'b10; end
            S_HALT:      begin hlt = 1; end
            default:     begin end
        endcase
        if (!en || rst) begin pcw = 0; irw = 0; memw = 0; regw = 0; end
        if (!en) isb = 0;
        return {st, pcw, pcs, isb, bt, iord, irw, memw, regw, m2r, srca,
                srcb, aluop, hlt, exp_illegal};
    endfunction

    // ---------------- monitor ----------------
    logic [21:0] mon_e;
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("outputs_in_state_%0d", mon_e[21:18]),
                  {10'd0, dut_vec}, {10'd0, mon_e});
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] st, input logic en, input logic rst,
                         input logic [6:0] op);
        Enable       = en;
        Reset        = rst;
        input_opcode = op;
        exp_q.push_back(exp_vec(st, en, rst));
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [3:0] st, input logic [6:0] op);
        drive(st, 1'b1, 1'b0, op);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        // Reset held for two cycles, then R-type.
        drive(S_FETCH, 1'b1, 1'b1, 7'h01);
        drive(S_FETCH, 1'b1, 1'b1, 7'h01);
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h01);
        run(S_EXEC_R, 7'h00);
        run(S_ALU_WB, 7'h00);
        // Load
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h03);
        run(S_MEM_ADDR, 7'h00);
        run(S_MEM_READ, 7'h00);
        run(S_MEM_WB, 7'h00);
        // Store, then branch 0x0A
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h04);
        run(S_MEM_ADDR, 7'h00);
        run(S_MEM_WRITE, 7'h00);
        exp_bt = 2'b10;
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h0A);
        run(S_BRANCH, 7'h00);
        // I-type
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h02);
        run(S_EXEC_I, 7'h00);
        run(S_ALU_WB, 7'h00);
        // Jump
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h0C);
        run(S_JUMP, 7'h00);
        // Store with Enable dropped for 3 cycles in MEM_WRITE
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h04);
        run(S_MEM_ADDR, 7'h00);
        drive(S_MEM_WRITE, 1'b0, 1'b0, 7'h00);
        drive(S_MEM_WRITE, 1'b0, 1'b0, 7'h00);
        drive(S_MEM_WRITE, 1'b0, 1'b0, 7'h00);
        run(S_MEM_WRITE, 7'h00);
        // Branch 0x09 with one stalled BRANCH cycle: isBranch must be 0 then.
        // The opcode changes during the stall to confirm branchType holds.
        exp_bt = 2'b01;
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h09);
        drive(S_BRANCH, 1'b0, 1'b0, 7'h0B);
        run(S_BRANCH, 7'h00);
        // Legal halt 0x7F: illegal stays 0; only reset leaves HALT.
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h7F);
        run(S_HALT, 7'h01);
        run(S_HALT, 7'h03);
        run(S_HALT, 7'h00);
        drive(S_FETCH, 1'b1, 1'b1, 7'h00);
        // Undefined opcode 0x55
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h55);
        exp_illegal = 1'b1;
        for (int i = 0; i < 10; i++) run(S_HALT, 7'h01);
        exp_illegal = 1'b0;
        drive(S_FETCH, 1'b1, 1'b1, 7'h00);
        // Async reset in the middle of MEM_READ
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h03);
        run(S_MEM_ADDR, 7'h00);
        Enable = 1'b1;
        input_opcode = 7'h00;
        #1;
        check("state_before_async_reset", {28'd0, output_state}, 32'd5);
        check("iord_before_async_reset", {31'd0, output_IorD}, 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("state_after_async_reset", {28'd0, output_state}, 32'd0);
        check("strobes_during_reset",
              {28'd0, output_PCWrite, output_IRWrite, output_MemWrite,
               output_RegWrite}, 32'd0);
        exp_q.push_back(exp_vec(S_FETCH, 1'b1, 1'b1));
        @(posedge CLK);
        #1;
        drive(S_FETCH, 1'b1, 1'b1, 7'h00);
        run(S_FETCH, 7'h00);
        run(S_DECODE, 7'h0C);
        run(S_JUMP, 7'h00);
        run(S_FETCH, 7'h00);
        @(negedge CLK);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
